booth_control_unit: RTL and testbench
=====================================

# booth_control_unit

Sequencer for the radix-2 Booth signed multiplier. It drives the one-hot-per-action control lines c0..c6 into the accumulator register A, the multiplier register Q (with Q[-1]), the multiplicand register M and the add/subtract unit. It decides add, subtract or skip from the Q[0]/Q[-1] pair each iteration. It counts WIDTH iterations, then sequences A and Q onto the shared outbus.

## Interface
Parameters:
- WIDTH, 8, operand width; iteration count.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- q0  input  1  current Q[0] from the Q register.
- q_1  input  1  current Q[-1] bit.
- c0  output  1  init: A<=0, Q[-1]<=0, Q<=inbus (multiplier).
- c1  output  1  load M from inbus (multiplicand).
- c2  output  1  A <= sum.
- c3  output  1  adder subtract select (A - M); only ever asserted with c2.
- c4  output  1  arithmetic right shift of A:Q:Q[-1].
- c5  output  1  drive A onto outbus.
- c6  output  1  drive Q onto outbus.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.

## Operation
- Moore FSM. All c*, busy and done decode from the state register only.
- States and transitions:
  - IDLE: start=1 goes to LOAD_Q; otherwise stays.
  - LOAD_Q (c0) goes to LOAD_M.
  - LOAD_M (c1) goes to TEST.
  - TEST (no outputs) branches on {q0,q_1}: 10 goes to SUB, 01 goes to ADD, 00 or 11 goes to SHIFT.
  - ADD (c2) goes to SHIFT.
  - SUB (c2, c3) goes to SHIFT.
  - SHIFT (c4) increments the counter. If the counter was WIDTH-1, go to OUT_A; else go to TEST.
  - OUT_A (c5) goes to OUT_Q.
  - OUT_Q (c6) goes to DONE.
  - DONE (done) goes to IDLE.
- Counter:
  - CNT_W bits, cleared in LOAD_Q.
  - Wraps to 0 on the final SHIFT.
  - Never compared outside SHIFT.
- At most one of c0, c1, c2, c4, c5, c6 is high in any cycle. c3 implies c2.
- start while busy is ignored and does not queue.
- start held high across DONE begins a new multiply from IDLE on the following edge.
- q0/q_1 are sampled only in TEST. Values in other states are don't-care.

## Timing
- Reset: state=IDLE, counter=0. c0..c6=0, busy=0, done=0 from the cycle after the rst edge.
- Reset in any state, including mid-iteration, aborts with the same result. No partial shift or add is issued after the reset edge.
- Cycle numbering: start sampled at edge 0.
  - Cycle 1: LOAD_Q.
  - Cycle 2: LOAD_M.
  - Cycle 3: first TEST.
- Per iteration: 2 cycles (skip) or 3 cycles (add/sub).
- done cycle = 5 + 2*WIDTH + (number of add/sub iterations), plus the two load cycles already counted:
  - WIDTH=8: minimum 21, maximum 29.
- DONE lasts exactly one cycle. busy drops in the cycle after DONE (IDLE).
- The datapath updates Q at the SHIFT edge, so q0/q_1 are valid by the next TEST.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE, LOAD_Q, LOAD_M, TEST, ADD, SUB, SHIFT, OUT_A, OUT_Q, DONE);
  - the default WIDTH;
  - named index constants for c0..c6, shared with the datapath registers.
- One sub-module, booth_iter_counter, with clear, increment and last flag (count==WIDTH-1). The FSM and output decode stay in booth_control_unit.

## Test plan
Bench uses a behavioural Q/Q[-1] model driven by c0/c4 and inbus.
- Reset: rst high 2 cycles, then low with start=0. All outputs 0 and busy=0 for 10 cycles.
- Multiplier 0x00: start at edge 0.
  - c0 in cycle 1, c1 in cycle 2.
  - c2 never asserted, eight c4 pulses.
  - c5 in cycle 19, c6 in cycle 20, done in cycle 21.
- Multiplier 0x55: every iteration alternates SUB/ADD, giving 8 c2 pulses (c3 on iterations 0, 2, 4, 6); done in cycle 29.
- Multiplier 0x03:
  - iteration 0 is SUB (c2+c3);
  - iteration 1 is skip;
  - iteration 2 is ADD (c2 only);
  - iterations 3..7 are skip;
  - done in cycle 23.
- start pulsed in cycles 5 and 12 of an active multiply: no effect; the sequence and done cycle are identical to the undisturbed run.
- rst asserted in a SUB cycle: next cycle all c*=0 and busy=0. A fresh start then completes normally, with the counter starting from 0 (eight c4 pulses).

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier control path.
//   state_t      : sequencer state encoding
//   DEFAULT_WIDTH: default operand width / iteration count
//   C*_IDX       : bit positions of the control lines c0..c6 in a control
//                  vector, shared with the datapath register decode
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam int C0_IDX   = 0;  // init A, Q[-1]; load Q (multiplier)
  localparam int C1_IDX   = 1;  // load M (multiplicand)
  localparam int C2_IDX   = 2;  // A <= sum
  localparam int C3_IDX   = 3;  // adder subtract select
  localparam int C4_IDX   = 4;  // arithmetic right shift A:Q:Q[-1]
  localparam int C5_IDX   = 5;  // A onto outbus
  localparam int C6_IDX   = 6;  // Q onto outbus
  localparam int NUM_CTRL = 7;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_Q,
    LOAD_M,
    TEST,
    ADD,
    SUB,
    SHIFT,
    OUT_A,
    OUT_Q,
    DONE
  } state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to 0
//   inc      : advance count; wraps to 0 after WIDTH-1
//   last     : count == WIDTH-1 (current iteration is the final one)
module booth_iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] count;

  assign last = (count == CNT_W'(WIDTH - 1));

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather
  // than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      // Explicit wrap keeps non-power-of-two widths correct.
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/booth_control_unit.sv
// Moore sequencer for the radix-2 Booth signed multiplier.
//   clk, rst   : clock, synchronous active-high reset
//   start      : multiply request, sampled only in IDLE
//   q0, q_1    : Q[0] and Q[-1] from the datapath, sampled only in TEST
//   c0..c6     : datapath control lines (see booth_pkg index constants)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at the end of a multiply
module booth_control_unit
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic done
);

  state_t state_q, state_d;
  logic   last;
  logic [NUM_CTRL-1:0] ctrl;

  booth_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == LOAD_Q),
    .inc   (state_q == SHIFT),
    .last  (last)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD_Q;
      end
      LOAD_Q: begin
        ctrl[C0_IDX] = 1'b1;
        state_d      = LOAD_M;
      end
      LOAD_M: begin
        ctrl[C1_IDX] = 1'b1;
        state_d      = TEST;
      end
      TEST: begin
        // Booth recoding: 10 -> subtract M, 01 -> add M, 00/11 -> shift only.
        unique case ({q0, q_1})
          2'b10:   state_d = SUB;
          2'b01:   state_d = ADD;
          default: state_d = SHIFT;
        endcase
      end
      ADD: begin
        ctrl[C2_IDX] = 1'b1;
        state_d      = SHIFT;
      end
      SUB: begin
        ctrl[C2_IDX] = 1'b1;
        ctrl[C3_IDX] = 1'b1;
        state_d      = SHIFT;
      end
      SHIFT: begin
        ctrl[C4_IDX] = 1'b1;
        state_d      = last ? OUT_A : TEST;
      end
      OUT_A: begin
        ctrl[C5_IDX] = 1'b1;
        state_d      = OUT_Q;
      end
      OUT_Q: begin
        ctrl[C6_IDX] = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign c0 = ctrl[C0_IDX];
  assign c1 = ctrl[C1_IDX];
  assign c2 = ctrl[C2_IDX];
  assign c3 = ctrl[C3_IDX];
  assign c4 = ctrl[C4_IDX];
  assign c5 = ctrl[C5_IDX];
  assign c6 = ctrl[C6_IDX];

endmodule

// File: tb/tb_booth_control_unit.sv
// Self-checking bench for booth_control_unit. A small Q/Q[-1] register model
// reacts to c0/c4; the expected per-cycle control trace is derived from the
// Booth recoding rule applied directly to the multiplier bits.
module tb_booth_control_unit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, start, q0, q_1;
  logic c0, c1, c2, c3, c4, c5, c6, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Datapath stand-in: Q register and Q[-1].
  logic [W-1:0] inbus_q;
  logic [W-1:0] q_reg;
  logic         q_m1;

  always #5 clk = ~clk;

  booth_control_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q0    (q0),
    .q_1   (q_1),
    .c0    (c0),
    .c1    (c1),
    .c2    (c2),
    .c3    (c3),
    .c4    (c4),
    .c5    (c5),
    .c6    (c6),
    .busy  (busy),
    .done  (done)
  );

  always @(posedge clk) begin
    if (c0) begin
      q_reg <= inbus_q;
      q_m1  <= 1'b0;
    end else if (c4) begin
      q_m1  <= q_reg[0];
      q_reg <= {q_reg[W-1], q_reg[W-1:1]};
    end
  end

  assign q0  = q_reg[0];
  assign q_1 = q_m1;

  // Observed vector: {busy, done, c6, c5, c4, c3, c2, c1, c0}
  function automatic logic [8:0] obs();
    return {busy, done, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected trace, indexed by cycle number (cycle 1 = LOAD_Q).
  logic [8:0] exp_trace [1:40];

  task automatic build_trace(input logic [W-1:0] mult, output int last_cycle, output int n_ops);
    int  k;
    logic prev;
    k     = 1;
    n_ops = 0;
    prev  = 1'b0;
    exp_trace[k] = 9'h101; k++;            // c0
    exp_trace[k] = 9'h102; k++;            // c1
    for (int i = 0; i < W; i++) begin
      exp_trace[k] = 9'h100; k++;          // decision cycle, no controls
      if (mult[i] && !prev) begin
        exp_trace[k] = 9'h10C; k++; n_ops++;  // subtract: c2 + c3
      end else if (!mult[i] && prev) begin
        exp_trace[k] = 9'h104; k++; n_ops++;  // add: c2
      end
      exp_trace[k] = 9'h110; k++;          // c4
      prev = mult[i];
    end
    exp_trace[k] = 9'h120; k++;            // c5
    exp_trace[k] = 9'h140; k++;            // c6
    exp_trace[k] = 9'h180;                 // done
    last_cycle = k;
  endtask

  // Entered at a negedge in IDLE. disturb pulses start in cycles 5 and 12;
  // abort_cycle > 0 asserts rst after that cycle and returns.
  task automatic run_mult(input logic [W-1:0] mult, input bit disturb, input int abort_cycle);
    int last_cycle, n_ops, done_seen, c4_seen;
    build_trace(mult, last_cycle, n_ops);
    inbus_q   = mult;
    done_seen = -1;
    c4_seen   = 0;
    start     = 1'b1;
    for (int k = 1; k <= last_cycle; k++) begin
      @(negedge clk);
      start = disturb && (k == 5 || k == 12);
      check($sformatf("m%02h cyc%0d", mult, k), 32'(obs()), 32'(exp_trace[k]));
      if (done) done_seen = k;
      if (c4) c4_seen++;
      if (k == abort_cycle) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("m%02h abort", mult), 32'(obs()), 32'h0);
        return;
      end
    end
    check($sformatf("m%02h done_cycle", mult), done_seen, 5 + 2 * W + n_ops);
    check($sformatf("m%02h shifts", mult), c4_seen, W);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("m%02h idle", mult), 32'(obs()), 32'h0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    inbus_q = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("reset idle %0d", i), 32'(obs()), 32'h0);
    end

    run_mult(8'h00, 1'b0, 0);
    run_mult(8'h55, 1'b0, 0);
    run_mult(8'h03, 1'b0, 0);
    run_mult(8'h03, 1'b1, 0);      // stray start pulses while busy
    run_mult(8'h55, 1'b0, 10);     // cycle 10 is the second SUB
    run_mult(8'h00, 1'b0, 0);      // fresh run after abort

    // Back-to-back runs: start is raised in the IDLE cycle right after done.
    for (int i = 0; i < 16; i++) begin
      run_mult(W'($urandom), 1'($urandom_range(0, 1)), 0);
    end
    run_mult(8'hFF, 1'b0, 0);
    run_mult(8'h80, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
